writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Parametrised write-back stage of the RISC pipeline.
- Registers one MEM/WB transaction per cycle and selects the result source (ALU, memory, immediate, PC).
- Drives the GPR file write port or the private-register (SP) write port.
- Supports double-width ALU results (e.g. MUL) as a two-beat write to Rd and Rd+1; stalls upstream for one cycle during the second beat.
- Exports write and pending-write information to the hazard/forwarding unit.

Parameters:
- DATA_W, 16, register/data width in bits
- ADDR_W, 3, GPR address width (2^ADDR_W registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  MEM/WB transaction present
- in_ready  out  1  stage can accept; combinational, equals !hi_pending
- in_reg_write  in  1  transaction writes a register
- in_src  in  2  result source: 00 ALU low half, 01 memory, 10 immediate, 11 PC
- in_dst_addr  in  ADDR_W  destination GPR
- in_dst_private  in  1  1 = write private register (SP), not the GPR file
- in_wide  in  1  2*DATA_W ALU result, written over two beats
- in_alu_data  in  2*DATA_W  ALU result; high half used only when wide
- in_mem_data  in  DATA_W  memory read data
- in_imm_data  in  DATA_W  immediate
- in_pc_data  in  DATA_W  PC value
- flush  in  1  kill the current and pending transaction
- rf_we  out  1  GPR write enable
- rf_waddr  out  ADDR_W  GPR write address
- rf_wdata  out  DATA_W  GPR write data
- priv_we  out  1  private-register write enable
- priv_wdata  out  DATA_W  private-register write data
- fwd_pend_valid  out  1  high-half write pending next cycle
- fwd_pend_addr  out  ADDR_W  address of the pending high-half write

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - rf_we, priv_we, fwd_pend_valid and hi_pending are cleared.
  - rf_waddr, rf_wdata, priv_wdata and fwd_pend_addr are cleared to 0.
  - in_ready=1 after the reset edge.
  - Reset overrides flush and any capture, including mid two-beat operation.
- Accept: transfer occurs when in_valid & in_ready & !flush at a rising edge.
- Latency: outputs are registered. The write is visible exactly 1 cycle after acceptance and lasts 1 cycle unless another transfer follows.
- Source mux on accept: data = ALU[DATA_W-1:0] / mem / imm / pc according to in_src.
- Effective wide: wide_eff = in_wide & (in_src==00) & !in_dst_private. Otherwise in_wide is ignored, giving a single beat.
- Write-enable gating on accept:
  - rf_we = in_reg_write & !in_dst_private
  - priv_we = in_reg_write & in_dst_private
  - rf_waddr and rf_wdata (or priv_wdata) load on every accept, even when the enable is 0.
- No accept and no pending beat: rf_we and priv_we are 0 next cycle; address and data hold their values.
- FSM (hi_pending flag), states IDLE and HI:
  - IDLE -> HI: on accept with wide_eff & in_reg_write. The low beat is issued next cycle. The high half and Rd+1 are latched internally. fwd_pend_valid=1 and fwd_pend_addr=Rd+1 during the low-beat cycle.
  - HI: in_ready=0.
  - HI -> IDLE: at the next edge, rf_we=1, rf_waddr=Rd+1, rf_wdata=high half, fwd_pend_valid=0.
  - One bubble per wide op. A new transaction can be accepted in the cycle the high beat is visible.
- Wrap-around: Rd+1 is computed modulo 2^ADDR_W, so Rd=7 with ADDR_W=3 gives address 0.
- Wide with in_reg_write=0: no writes and no HI state.
- Flush (synchronous, priority below reset):
  - Any same-cycle input is discarded.
  - hi_pending and fwd_pend_valid are cleared, and rf_we and priv_we are 0 next cycle.
  - A low beat already visible in the flush cycle completes. The high beat is cancelled.
- in_valid=0: no state change except completion of a pending high beat.

Test Plan:
- Reset then single ALU write: src=00, Rd=3, alu=0x0000_1234, reg_write=1 -> next cycle rf_we=1, waddr=3, wdata=0x1234. Following idle cycle rf_we=0. in_ready stays 1.
- Source select: back-to-back accepts with src=01 mem=0xBEEF, then src=10 imm=0x00FF, then src=11 pc=0x0200 -> rf_wdata=0xBEEF, 0x00FF, 0x0200 on three consecutive cycles, no bubbles.
- Wide write with wrap: Rd=7, alu=0xAAAA_5555, wide=1 -> cycle+1: waddr=7, wdata=0x5555, in_ready=0, fwd_pend_valid=1, fwd_pend_addr=0. Cycle+2: waddr=0, wdata=0xAAAA, in_ready=1.
- Private write: dst_private=1, wide=1, src=00, alu=0x1111_0FFE -> priv_we=1, priv_wdata=0x0FFE, rf_we=0, no second beat, in_ready never drops.
- Flush mid-wide: flush=1 in the low-beat cycle -> low write to Rd occurs. Next cycle rf_we=0, fwd_pend_valid=0, in_ready=1. Flush asserted together with in_valid -> that transaction never writes.
- Reset mid-wide: rst_n=0 in the low-beat cycle -> next cycle all enables 0, outputs 0, in_ready=1, no high beat.

Source files
------------

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : MEM/WB register, result-source select, GPR/SP write ports and
//            two-beat write of double-width ALU results (Rd, then Rd+1).
// Revision : 1.0
// ============================================================================
module writeback_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_src,
    input  logic [ADDR_W-1:0]     in_dst_addr,
    input  logic                  in_dst_private,
    input  logic                  in_wide,
    input  logic [2*DATA_W-1:0]   in_alu_data,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [DATA_W-1:0]     in_imm_data,
    input  logic [DATA_W-1:0]     in_pc_data,
    input  logic                  flush,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  priv_we,
    output logic [DATA_W-1:0]     priv_wdata,
    output logic                  fwd_pend_valid,
    output logic [ADDR_W-1:0]     fwd_pend_addr
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HI   = 1'b1
    } state_t;

    localparam logic [1:0] c_SRC_ALU = 2'b00;
    localparam logic [1:0] c_SRC_MEM = 2'b01;
    localparam logic [1:0] c_SRC_IMM = 2'b10;

    state_t              r_state;
    logic [DATA_W-1:0]   r_hi_data;
    logic [ADDR_W-1:0]   r_hi_addr;

    logic                w_accept;
    logic                w_wide_eff;
    logic [DATA_W-1:0]   w_src_data;
    logic [ADDR_W-1:0]   w_rd_plus1;

    assign in_ready   = (r_state == S_IDLE);
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_wide_eff = in_wide & (in_src == c_SRC_ALU) & ~in_dst_private;
    // Natural truncation gives the modulo-2^ADDR_W wrap of Rd+1.
    assign w_rd_plus1 = in_dst_addr + 1'b1;

    always_comb begin
        w_src_data = in_pc_data;
        case (in_src)
            c_SRC_ALU: w_src_data = in_alu_data[DATA_W-1:0];
            c_SRC_MEM: w_src_data = in_mem_data;
            c_SRC_IMM: w_src_data = in_imm_data;
            default:   w_src_data = in_pc_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_hi_data      <= '0;
            r_hi_addr      <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            priv_we        <= 1'b0;
            priv_wdata     <= '0;
            fwd_pend_valid <= 1'b0;
            fwd_pend_addr  <= '0;
        end else if (flush) begin
            // The low beat already on the outputs has been seen; only the high beat dies.
            r_state        <= S_IDLE;
            rf_we          <= 1'b0;
            priv_we        <= 1'b0;
            fwd_pend_valid <= 1'b0;
        end else if (r_state == S_HI) begin
            r_state        <= S_IDLE;
            rf_we          <= 1'b1;
            rf_waddr       <= r_hi_addr;
            rf_wdata       <= r_hi_data;
            priv_we        <= 1'b0;
            fwd_pend_valid <= 1'b0;
        end else if (w_accept) begin
            rf_we    <= in_reg_write & ~in_dst_private;
            priv_we  <= in_reg_write & in_dst_private;
            rf_waddr <= in_dst_addr;
            if (in_dst_private) begin
                priv_wdata <= w_src_data;
            end else begin
                rf_wdata   <= w_src_data;
            end
            if (w_wide_eff && in_reg_write) begin
                r_state        <= S_HI;
                r_hi_data      <= in_alu_data[2*DATA_W-1:DATA_W];
                r_hi_addr      <= w_rd_plus1;
                fwd_pend_valid <= 1'b1;
                fwd_pend_addr  <= w_rd_plus1;
            end else begin
                fwd_pend_valid <= 1'b0;
            end
        end else begin
            rf_we          <= 1'b0;
            priv_we        <= 1'b0;
            fwd_pend_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Directed plus random stimulus against a queue-based write model.
// Revision : 1.0
// ============================================================================
module tb_writeback_stage;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_reg_write;
    logic [1:0]          in_src;
    logic [ADDR_W-1:0]   in_dst_addr;
    logic                in_dst_private;
    logic                in_wide;
    logic [2*DATA_W-1:0] in_alu_data;
    logic [DATA_W-1:0]   in_mem_data;
    logic [DATA_W-1:0]   in_imm_data;
    logic [DATA_W-1:0]   in_pc_data;
    logic                flush;
    logic                rf_we;
    logic [ADDR_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                priv_we;
    logic [DATA_W-1:0]   priv_wdata;
    logic                fwd_pend_valid;
    logic [ADDR_W-1:0]   fwd_pend_addr;

    writeback_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (in_reg_write),
        .in_src         (in_src),
        .in_dst_addr    (in_dst_addr),
        .in_dst_private (in_dst_private),
        .in_wide        (in_wide),
        .in_alu_data    (in_alu_data),
        .in_mem_data    (in_mem_data),
        .in_imm_data    (in_imm_data),
        .in_pc_data     (in_pc_data),
        .flush          (flush),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .priv_we        (priv_we),
        .priv_wdata     (priv_wdata),
        .fwd_pend_valid (fwd_pend_valid),
        .fwd_pend_addr  (fwd_pend_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: outputs plus a queue of outstanding high beats.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t             hiq[$];
    logic              m_rf_we, m_priv_we, m_pend_valid;
    logic [ADDR_W-1:0] m_waddr, m_pend_addr;
    logic [DATA_W-1:0] m_wdata, m_priv_wdata;

    task automatic model_edge();
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] nxt;
        beat_t             b;
        if (!rst_n) begin
            hiq.delete();
            m_rf_we = 0; m_priv_we = 0; m_pend_valid = 0;
            m_waddr = 0; m_wdata = 0; m_priv_wdata = 0; m_pend_addr = 0;
        end else if (flush) begin
            hiq.delete();
            m_rf_we = 0; m_priv_we = 0; m_pend_valid = 0;
        end else if (hiq.size() != 0) begin
            b = hiq.pop_front();
            m_rf_we = 1; m_priv_we = 0; m_pend_valid = 0;
            m_waddr = b.addr; m_wdata = b.data;
        end else if (in_valid) begin
            d = (in_src == 2'd0) ? in_alu_data[DATA_W-1:0] :
                (in_src == 2'd1) ? in_mem_data :
                (in_src == 2'd2) ? in_imm_data : in_pc_data;
            m_waddr   = in_dst_addr;
            m_rf_we   = in_reg_write && !in_dst_private;
            m_priv_we = in_reg_write && in_dst_private;
            if (in_dst_private) m_priv_wdata = d;
            else                m_wdata      = d;
            m_pend_valid = 0;
            if (in_wide && in_src == 2'd0 && !in_dst_private && in_reg_write) begin
                nxt = ADDR_W'((int'(in_dst_addr) + 1) % (1 << ADDR_W));
                b.addr = nxt;
                b.data = in_alu_data[2*DATA_W-1:DATA_W];
                hiq.push_back(b);
                m_pend_valid = 1;
                m_pend_addr  = nxt;
            end
        end else begin
            m_rf_we = 0; m_priv_we = 0; m_pend_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("in_ready",       32'(in_ready),       32'(hiq.size() == 0));
        check("rf_we",          32'(rf_we),          32'(m_rf_we));
        check("rf_waddr",       32'(rf_waddr),       32'(m_waddr));
        check("rf_wdata",       32'(rf_wdata),       32'(m_wdata));
        check("priv_we",        32'(priv_we),        32'(m_priv_we));
        check("priv_wdata",     32'(priv_wdata),     32'(m_priv_wdata));
        check("fwd_pend_valid", 32'(fwd_pend_valid), 32'(m_pend_valid));
        check("fwd_pend_addr",  32'(fwd_pend_addr),  32'(m_pend_addr));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [ADDR_W-1:0] rd, input logic prv, input logic wd,
                         input logic [31:0] alu, input logic [15:0] mem,
                         input logic [15:0] imm, input logic [15:0] pc, input logic fl);
        in_valid = v; in_reg_write = rw; in_src = src; in_dst_addr = rd;
        in_dst_private = prv; in_wide = wd; in_alu_data = alu;
        in_mem_data = mem; in_imm_data = imm; in_pc_data = pc; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 2'd0, 3'd0, 0, 0, 32'h0, 16'h0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        rst_n = 0;
        idle();
        step();
        step();
        check("reset_rf_we", 32'(rf_we), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1;

        // Single ALU write
        drive(1, 1, 2'd0, 3'd3, 0, 0, 32'h0000_1234, 16'h0, 16'h0, 16'h0, 0);
        step();
        check("alu_wdata_const", 32'(rf_wdata), 32'h1234);
        idle();
        step();

        // Back-to-back mem / imm / pc sources
        drive(1, 1, 2'd1, 3'd1, 0, 0, 32'h0, 16'hBEEF, 16'h0, 16'h0, 0); step();
        check("mem_const", 32'(rf_wdata), 32'hBEEF);
        drive(1, 1, 2'd2, 3'd2, 0, 0, 32'h0, 16'h0, 16'h00FF, 16'h0, 0); step();
        check("imm_const", 32'(rf_wdata), 32'h00FF);
        drive(1, 1, 2'd3, 3'd4, 0, 0, 32'h0, 16'h0, 16'h0, 16'h0200, 0); step();
        check("pc_const", 32'(rf_wdata), 32'h0200);
        idle(); step();

        // Wide write to Rd=7 wraps high beat to address 0
        drive(1, 1, 2'd0, 3'd7, 0, 1, 32'hAAAA_5555, 16'h0, 16'h0, 16'h0, 0); step();
        check("wide_lo_const", 32'(rf_wdata), 32'h5555);
        check("wide_pend_const", 32'(fwd_pend_addr), 32'd0);
        idle(); step();
        check("wide_hi_const", 32'(rf_wdata), 32'hAAAA);
        step();

        // Private destination ignores wide
        drive(1, 1, 2'd0, 3'd5, 1, 1, 32'h1111_0FFE, 16'h0, 16'h0, 16'h0, 0); step();
        check("priv_const", 32'(priv_wdata), 32'h0FFE);
        idle(); step();

        // Flush during low-beat cycle, then flush with a valid input
        drive(1, 1, 2'd0, 3'd2, 0, 1, 32'hCAFE_F00D, 16'h0, 16'h0, 16'h0, 0); step();
        idle(); flush = 1; step();
        flush = 0; step();
        drive(1, 1, 2'd1, 3'd6, 0, 0, 32'h0, 16'h7777, 16'h0, 16'h0, 1); step();
        idle(); step();

        // Reset during low-beat cycle
        drive(1, 1, 2'd0, 3'd4, 0, 1, 32'h1357_2468, 16'h0, 16'h0, 16'h0, 0); step();
        idle(); rst_n = 0; step();
        rst_n = 1; step();

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom, 16'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 40) != 0);
            step();
        end
        rst_n = 1;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
